// File: rtl/sn74ls107_pkg.sv
// Shared definitions for the sn74ls107 dual JK flip-flop: J/K mode codes,
// the default clear value and the next-state rule.
package sn74ls107_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  localparam logic RESET_Q_DEFAULT = 1'b0;

  function automatic logic jk_next(input logic [1:0] mode, input logic q);
    logic nxt;
    nxt = q;
    case (mode)
      JK_HOLD:   nxt = q;
      JK_RESET:  nxt = 1'b0;
      JK_SET:    nxt = 1'b1;
      JK_TOGGLE: nxt = ~q;
      default:   nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sn74ls107_jk_ff.sv
// Single JK flip-flop with synchronous active-low clear. Q and Q_bar are
// separate registers loaded from one next-state value, so they never disagree.
module jk_ff
  import sn74ls107_pkg::*;
#(
  parameter logic RESET_Q = RESET_Q_DEFAULT
) (
  input  logic CLK,
  input  logic CLR_bar,
  input  logic J,
  input  logic K,
  output logic Q,
  output logic Q_bar
);

  logic q_q;
  logic qb_q;
  logic q_d;

  always_comb begin
    q_d = jk_next({J, K}, q_q);
  end

  // Clear wins over any J/K mode on the same edge.
  always_ff @(posedge CLK) begin
    if (!CLR_bar) begin
      q_q  <= RESET_Q;
      qb_q <= ~RESET_Q;
    end else begin
      q_q  <= q_d;
      qb_q <= ~q_d;
    end
  end

  assign Q     = q_q;
  assign Q_bar = qb_q;

endmodule

// File: rtl/sn74ls107.sv
// Dual JK flip-flop with shared clock and synchronous clear (74LS107 model).
// Define SN74LS107_CHAN_CLR_EN to add per-flip-flop clears CLR_bar_1/CLR_bar_2.
module sn74ls107
  import sn74ls107_pkg::*;
#(
  parameter logic RESET_Q_1 = RESET_Q_DEFAULT,
  parameter logic RESET_Q_2 = RESET_Q_DEFAULT
) (
  input  logic CLK,
  input  logic CLR_bar,
`ifdef SN74LS107_CHAN_CLR_EN
  input  logic CLR_bar_1,
  input  logic CLR_bar_2,
`endif
  input  logic J_1,
  input  logic K_1,
  output logic Q_1,
  output logic Q_bar_1,
  input  logic J_2,
  input  logic K_2,
  output logic Q_2,
  output logic Q_bar_2
);

  logic clr1_n;
  logic clr2_n;

`ifdef SN74LS107_CHAN_CLR_EN
  assign clr1_n = CLR_bar & CLR_bar_1;
  assign clr2_n = CLR_bar & CLR_bar_2;
`else
  assign clr1_n = CLR_bar;
  assign clr2_n = CLR_bar;
`endif

  jk_ff #(.RESET_Q(RESET_Q_1)) u_ff1 (
    .CLK     (CLK),
    .CLR_bar (clr1_n),
    .J       (J_1),
    .K       (K_1),
    .Q       (Q_1),
    .Q_bar   (Q_bar_1)
  );

  jk_ff #(.RESET_Q(RESET_Q_2)) u_ff2 (
    .CLK     (CLK),
    .CLR_bar (clr2_n),
    .J       (J_2),
    .K       (K_2),
    .Q       (Q_2),
    .Q_bar   (Q_bar_2)
  );

endmodule

// File: tb/tb_sn74ls107.sv
// Bench for sn74ls107: directed vectors on one device plus a three-device
// six-stage ring counter, checked against a behavioural model every cycle.
module tb_sn74ls107;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clr_n = 1'b1;
  logic c1 = 1'b1;
  logic c2 = 1'b1;
  logic j1 = 1'b0, k1 = 1'b0, j2 = 1'b0, k2 = 1'b0;
  logic q1, qb1, q2, qb2;

  int checks = 0;
  int failures = 0;

  sn74ls107 u_dut (
    .CLK       (clk),
    .CLR_bar   (clr_n),
`ifdef SN74LS107_CHAN_CLR_EN
    .CLR_bar_1 (c1),
    .CLR_bar_2 (c2),
`endif
    .J_1       (j1),
    .K_1       (k1),
    .Q_1       (q1),
    .Q_bar_1   (qb1),
    .J_2       (j2),
    .K_2       (k2),
    .Q_2       (q2),
    .Q_bar_2   (qb2)
  );

  // Ring counter: stage index 0..5 is T1..T6; T1 is held inverted in stage 0.
  logic       rclr_n = 1'b1;
  logic [5:0] rj, rk, rq, rqb, tv;

  assign rj[0] = rqb[5];
  assign rk[0] = rq[5];
  assign rj[1] = rqb[0];
  assign rk[1] = rq[0];
  assign rj[5:2] = rq[4:1];
  assign rk[5:2] = rqb[4:1];
  assign tv = {rq[5:1], rqb[0]};

  for (genvar g = 0; g < 3; g++) begin : g_ring
    sn74ls107 u_r (
      .CLK       (clk),
      .CLR_bar   (rclr_n),
`ifdef SN74LS107_CHAN_CLR_EN
      .CLR_bar_1 (1'b1),
      .CLR_bar_2 (1'b1),
`endif
      .J_1       (rj[2*g]),
      .K_1       (rk[2*g]),
      .Q_1       (rq[2*g]),
      .Q_bar_1   (rqb[2*g]),
      .J_2       (rj[2*g+1]),
      .K_2       (rk[2*g+1]),
      .Q_2       (rq[2*g+1]),
      .Q_bar_2   (rqb[2*g+1])
    );
  end

  task automatic chk(input string name, input logic [5:0] act, input logic [5:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: characteristic equation Q+ = J~Q | ~KQ, clear first.
  logic mq1 = 1'b0, mq2 = 1'b0, mvalid = 1'b0;
  int   ridx = 0;
  logic rvalid = 1'b0;

  always @(posedge clk) begin
    if (!(clr_n & c1)) mq1 <= 1'b0;
    else               mq1 <= (j1 & ~mq1) | (~k1 & mq1);
    if (!(clr_n & c2)) mq2 <= 1'b0;
    else               mq2 <= (j2 & ~mq2) | (~k2 & mq2);
    if (!clr_n) mvalid <= 1'b1;
    if (!rclr_n) begin
      ridx   <= 0;
      rvalid <= 1'b1;
    end else if (rvalid) begin
      ridx <= (ridx + 1) % 6;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("model_q1",  {5'b0, q1},  {5'b0, mq1});
      chk("model_qb1", {5'b0, qb1}, {5'b0, ~mq1});
      chk("model_q2",  {5'b0, q2},  {5'b0, mq2});
      chk("model_qb2", {5'b0, qb2}, {5'b0, ~mq2});
    end
    if (rvalid) chk("ring_onehot", tv, 6'b000001 << ridx);
  end

  task automatic step(input logic jj1, input logic kk1, input logic jj2,
                      input logic kk2, input logic cl);
    j1 = jj1; k1 = kk1; j2 = jj2; k2 = kk2; clr_n = cl;
    @(posedge clk);
    #2;
  endtask

  logic [1:0] t2_jk [6] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b00};
  logic       t2_q  [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    @(posedge clk);
    #2;
    // Reset with toggle requested on both; ring cleared on the same edge.
    rclr_n = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    rclr_n = 1'b1;
    chk("rst_q1",  {5'b0, q1},  6'd0);
    chk("rst_qb1", {5'b0, qb1}, 6'd1);
    chk("rst_q2",  {5'b0, q2},  6'd0);
    chk("rst_qb2", {5'b0, qb2}, 6'd1);
    chk("ring_after_clr", tv, 6'b000001);

    // Mode table on flip-flop 1.
    for (int i = 0; i < 6; i++) begin
      step(t2_jk[i][1], t2_jk[i][0], 1'b0, 1'b0, 1'b1);
      chk("mode_q1",  {5'b0, q1},  {5'b0, t2_q[i]});
      chk("mode_qb1", {5'b0, qb1}, {5'b0, ~t2_q[i]});
    end

    // Independence: set Q_2, then toggle flip-flop 1 for 8 edges.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      chk("indep_q2",  {5'b0, q2},  6'd1);
      chk("indep_qb2", {5'b0, qb2}, 6'd0);
      chk("indep_q1",  {5'b0, q1},  {5'b0, ~i[0]});
    end

    // Glitch on CLR_bar between edges must not clear.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    j1 = 1'b0; k1 = 1'b0; j2 = 1'b0; k2 = 1'b0;
    #1 clr_n = 1'b0;
    #1 clr_n = 1'b1;
    @(posedge clk);
    #2;
    chk("glitch_q1", {5'b0, q1}, 6'd1);
    chk("glitch_q2", {5'b0, q2}, 6'd1);

    // Reset priority over toggle, from Q=1 and from Q=0.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_q1_from1", {5'b0, q1}, 6'd0);
    chk("prio_q2_from1", {5'b0, q2}, 6'd0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("prio_q1_from0", {5'b0, q1}, 6'd0);
    chk("prio_qb2_from0", {5'b0, qb2}, 6'd1);

    // Ring: re-clear mid-run, then run two full periods.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rclr_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    rclr_n = 1'b1;
    chk("ring_reclr", tv, 6'b000001);
    for (int i = 1; i <= 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("ring_walk", tv, 6'b000001 << (i % 6));
    end

`ifdef SN74LS107_CHAN_CLR_EN
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    c2 = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    c2 = 1'b1;
    chk("chan_q2", {5'b0, q2}, 6'd0);
    chk("chan_q1", {5'b0, q1}, 6'd1);
    c1 = 1'b0;
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    c1 = 1'b1;
    chk("chan_q1_clr", {5'b0, q1}, 6'd0);
    chk("chan_q2_set", {5'b0, q2}, 6'd1);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
